// File: rtl/vga_pkg.sv
// Shared definitions for the VGA pixel path.
// Contents: visible-area constants, the 11-bit position type, the packed
// 2-bit-per-channel colour type, the sprite palette and fixed colours.
package vga_pkg;

    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned V_ACTIVE = 480;

    // Position width is one bit wider than hpos/vpos so pos+step never wraps.
    typedef logic [10:0] pos_t;

    typedef struct packed {
        logic [1:0] r;
        logic [1:0] g;
        logic [1:0] b;
    } rgb_t;

    typedef enum logic {
        DIR_POS = 1'b0,
        DIR_NEG = 1'b1
    } dir_t;

    localparam rgb_t RGB_BLACK = 6'b00_00_00;
    localparam rgb_t RGB_WHITE = 6'b11_11_11;
    localparam rgb_t RGB_GRID  = 6'b01_01_01;

    // Element [3] is the left-most literal: 3=yellow, 2=blue, 1=green, 0=red.
    localparam rgb_t [3:0] PALETTE = {6'b11_11_00, 6'b00_00_11, 6'b00_11_00, 6'b11_00_00};

endpackage

// File: rtl/sprite_renderer_motion.sv
// sprite_motion: one axis of the bouncing sprite.
// Ports: clk, rst_n (async active-low), clk_en (pixel strobe), update (apply
// one step this tick), step (1..4 pixels), limit (largest legal position),
// pos (current position), dir (0 = increasing, 1 = decreasing),
// hit (combinational strobe: this update reaches a wall).
module sprite_motion
    import vga_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clk_en,
    input  logic       update,
    input  logic [2:0] step,
    input  pos_t       limit,
    output pos_t       pos,
    output logic       dir,
    output logic       hit
);

    pos_t pos_r;
    dir_t dir_r;
    pos_t next_pos_s;
    dir_t next_dir_s;
    logic hit_s;
    pos_t step_ext_s;

    assign step_ext_s = {8'b0000_0000, step};

    // Next position/direction with clamping onto the wall and reversal.
    always_comb begin
        next_pos_s = pos_r;
        next_dir_s = dir_r;
        hit_s      = 1'b0;
        case (dir_r)
            DIR_POS: begin
                if ((pos_r + step_ext_s) >= limit) begin
                    next_pos_s = limit;
                    next_dir_s = DIR_NEG;
                    hit_s      = 1'b1;
                end else begin
                    next_pos_s = pos_r + step_ext_s;
                end
            end
            DIR_NEG: begin
                if (pos_r <= step_ext_s) begin
                    next_pos_s = 11'd0;
                    next_dir_s = DIR_POS;
                    hit_s      = 1'b1;
                end else begin
                    next_pos_s = pos_r - step_ext_s;
                end
            end
            default: begin
                next_pos_s = 11'd0;
                next_dir_s = DIR_POS;
                hit_s      = 1'b0;
            end
        endcase
    end

    // Position/direction register, advanced once per frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_r <= 11'd0;
            dir_r <= DIR_POS;
        end else if (clk_en && update) begin
            pos_r <= next_pos_s;
            dir_r <= next_dir_s;
        end
    end

    assign pos = pos_r;
    assign dir = dir_r;
    assign hit = update & hit_s;

endmodule

// File: rtl/sprite_renderer.sv
// sprite_renderer: pixel colour stage after the VGA timing generator.
// Draws a bouncing square sprite (white 1-px border, palette fill) over a
// grid background, with a 2-tick pipeline that also re-times the syncs.
// Inputs: clk, rst_n, clk_en, active, hsync, vsync, v_begin, hpos, vpos,
//         pause, speed. Outputs: r, g, b, hsync_o, vsync_o, bounces.
module sprite_renderer
    import vga_pkg::*;
#(
    parameter int unsigned SPRITE_SIZE = 32,
    parameter int unsigned GRID_LOG2   = 5
)
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clk_en,
    input  logic       active,
    input  logic       hsync,
    input  logic       vsync,
    input  logic       v_begin,
    input  logic [9:0] hpos,
    input  logic [9:0] vpos,
    input  logic       pause,
    input  logic [1:0] speed,
    output logic [1:0] r,
    output logic [1:0] g,
    output logic [1:0] b,
    output logic       hsync_o,
    output logic       vsync_o,
    output logic [7:0] bounces
);

    localparam pos_t SIZE_P = pos_t'(SPRITE_SIZE);
    localparam pos_t XMAX_P = pos_t'(H_ACTIVE - SPRITE_SIZE);
    localparam pos_t YMAX_P = pos_t'(V_ACTIVE - SPRITE_SIZE);

    pos_t       x_s, y_s;
    logic       dx_s, dy_s, hit_x_s, hit_y_s;
    logic       dir_unused_s;
    logic       motion_upd_s;
    logic [2:0] step_s;
    pos_t       hpos_ext_s, vpos_ext_s;
    logic       in_sprite_s, on_border_s, on_grid_s;
    rgb_t       colour_s;

    logic       s1_active_r, s1_hsync_r, s1_vsync_r;
    logic       s1_in_sprite_r, s1_border_r, s1_grid_r;
    rgb_t       rgb_r;
    logic       hsync_o_r, vsync_o_r;
    logic [1:0] idx_r;
    logic [7:0] bounces_r;

    // speed is only consumed on the v_begin tick, so a mid-frame change waits a frame.
    assign motion_upd_s = clk_en & v_begin & ~pause;
    assign step_s       = {1'b0, speed} + 3'd1;
    assign dir_unused_s = dx_s ^ dy_s;

    sprite_motion u_motion_x (
        .clk    (clk),
        .rst_n  (rst_n),
        .clk_en (clk_en),
        .update (motion_upd_s),
        .step   (step_s),
        .limit  (XMAX_P),
        .pos    (x_s),
        .dir    (dx_s),
        .hit    (hit_x_s)
    );

    sprite_motion u_motion_y (
        .clk    (clk),
        .rst_n  (rst_n),
        .clk_en (clk_en),
        .update (motion_upd_s),
        .step   (step_s),
        .limit  (YMAX_P),
        .pos    (y_s),
        .dir    (dy_s),
        .hit    (hit_y_s)
    );

    assign hpos_ext_s  = {1'b0, hpos};
    assign vpos_ext_s  = {1'b0, vpos};
    assign in_sprite_s = (hpos_ext_s >= x_s) && (hpos_ext_s < (x_s + SIZE_P)) &&
                         (vpos_ext_s >= y_s) && (vpos_ext_s < (y_s + SIZE_P));
    assign on_border_s = in_sprite_s &&
                         ((hpos_ext_s == x_s) || (hpos_ext_s == (x_s + SIZE_P - 11'd1)) ||
                          (vpos_ext_s == y_s) || (vpos_ext_s == (y_s + SIZE_P - 11'd1)));
    assign on_grid_s   = (hpos[GRID_LOG2-1:0] == '0) || (vpos[GRID_LOG2-1:0] == '0);

    // Stage 1: geometric classification of the pixel plus sync/active delay.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_active_r    <= 1'b0;
            s1_hsync_r     <= 1'b1;
            s1_vsync_r     <= 1'b1;
            s1_in_sprite_r <= 1'b0;
            s1_border_r    <= 1'b0;
            s1_grid_r      <= 1'b0;
        end else if (clk_en) begin
            s1_active_r    <= active;
            s1_hsync_r     <= hsync;
            s1_vsync_r     <= vsync;
            s1_in_sprite_r <= in_sprite_s;
            s1_border_r    <= on_border_s;
            s1_grid_r      <= on_grid_s;
        end
    end

    // Colour priority: blanking, border, sprite fill, grid, background.
    always_comb begin
        colour_s = RGB_BLACK;
        if (!s1_active_r) begin
            colour_s = RGB_BLACK;
        end else if (s1_border_r) begin
            colour_s = RGB_WHITE;
        end else if (s1_in_sprite_r) begin
            colour_s = PALETTE[idx_r];
        end else if (s1_grid_r) begin
            colour_s = RGB_GRID;
        end else begin
            colour_s = RGB_BLACK;
        end
    end

    // Stage 2: registered colour and syncs toward the pins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_r     <= RGB_BLACK;
            hsync_o_r <= 1'b1;
            vsync_o_r <= 1'b1;
        end else if (clk_en) begin
            rgb_r     <= colour_s;
            hsync_o_r <= s1_hsync_r;
            vsync_o_r <= s1_vsync_r;
        end
    end

    // Palette index and wall-hit counter; a corner hit counts once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_r     <= 2'd0;
            bounces_r <= 8'd0;
        end else if (motion_upd_s && (hit_x_s || hit_y_s)) begin
            idx_r     <= idx_r + 2'd1;
            bounces_r <= bounces_r + 8'd1;
        end else begin
            idx_r     <= idx_r;
            bounces_r <= bounces_r;
        end
    end

    assign r       = rgb_r.r;
    assign g       = rgb_r.g;
    assign b       = rgb_r.b;
    assign hsync_o = hsync_o_r;
    assign vsync_o = vsync_o_r;
    assign bounces = bounces_r;

endmodule

// File: tb/tb_sprite_renderer.sv
// Scoreboard bench for sprite_renderer: stimulus pushes expected pixels,
// a monitor pops and compares two clk_en ticks later.
module tb_sprite_renderer;

    localparam int SZ   = 32;
    localparam int XMAX = 640 - SZ;
    localparam int YMAX = 480 - SZ;

    logic       clk = 1'b0;
    logic       rst_n, clk_en, active, hsync, vsync, v_begin, pause;
    logic [9:0] hpos, vpos;
    logic [1:0] speed;
    logic [1:0] r, g, b;
    logic       hsync_o, vsync_o;
    logic [7:0] bounces;

    sprite_renderer dut (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .active(active),
        .hsync(hsync), .vsync(vsync), .v_begin(v_begin), .hpos(hpos),
        .vpos(vpos), .pause(pause), .speed(speed), .r(r), .g(g), .b(b),
        .hsync_o(hsync_o), .vsync_o(vsync_o), .bounces(bounces)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] rgb;
        logic       hs;
        logic       vs;
        int         id;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   vec_id = 0;

    // Behavioural model state: position, direction (+1/-1), palette index, bounce count.
    int mx, my, mdx, mdy, midx, mbounce;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    function automatic logic [5:0] pal(input int i);
        case (i)
            0:       return 6'b11_00_00;
            1:       return 6'b00_11_00;
            2:       return 6'b00_00_11;
            default: return 6'b11_11_00;
        endcase
    endfunction

    function automatic logic [5:0] model_pix(input bit act, input int hp, input int vp);
        bit ins, brd, grd;
        if (!act) return 6'h00;
        ins = (hp >= mx) && (hp < mx + SZ) && (vp >= my) && (vp < my + SZ);
        brd = ins && (hp == mx || hp == mx + SZ - 1 || vp == my || vp == my + SZ - 1);
        grd = (hp % 32 == 0) || (vp % 32 == 0);
        if (brd) return 6'b11_11_11;
        if (ins) return pal(midx);
        if (grd) return 6'b01_01_01;
        return 6'h00;
    endfunction

    task automatic move_axis(inout int p, inout int d, input int lim, input int s, inout bit hit);
        if (d > 0) begin
            if (p + s >= lim) begin p = lim; d = -1; hit = 1'b1; end
            else p = p + s;
        end else begin
            if (p <= s) begin p = 0; d = 1; hit = 1'b1; end
            else p = p - s;
        end
    endtask

    task automatic model_motion(input int spd);
        bit hit = 1'b0;
        move_axis(mx, mdx, XMAX, spd + 1, hit);
        move_axis(my, mdy, YMAX, spd + 1, hit);
        if (hit) begin
            midx    = (midx + 1) % 4;
            mbounce = (mbounce + 1) % 256;
        end
    endtask

    task automatic model_reset();
        mx = 0; my = 0; mdx = 1; mdy = 1; midx = 0; mbounce = 0;
    endtask

    // One clk_en tick; fexp >= 0 overrides the model with a hand-derived colour.
    task automatic tick(input bit act, input bit hs, input bit vs, input bit vb,
                        input int hp, input int vp, input bit pz, input int spd,
                        input int fexp);
        exp_t e;
        int   ng;
        @(negedge clk);
        active = act; hsync = hs; vsync = vs; v_begin = vb;
        hpos = hp[9:0]; vpos = vp[9:0]; pause = pz; speed = spd[1:0];
        clk_en = 1'b1;
        e.rgb = (fexp >= 0) ? fexp[5:0] : model_pix(act, hp, vp);
        e.hs  = hs;
        e.vs  = vs;
        e.id  = vec_id++;
        sb.push_back(e);
        if (vb && !pz) model_motion(spd);
        @(posedge clk);
        #1;
        if (vb) check("bounces", {24'd0, bounces}, mbounce);
        ng = $urandom_range(0, 2);
        if (ng > 0) begin
            @(negedge clk);
            clk_en = 1'b0; v_begin = 1'b0;
            active = $urandom; hsync = $urandom; vsync = $urandom; pause = $urandom;
            hpos = $urandom; vpos = $urandom; speed = $urandom;
            repeat (ng) @(posedge clk);
        end
    endtask

    task automatic rand_pixel();
        int hp, vp;
        if ($urandom_range(0, 1) == 1) begin
            hp = mx + $urandom_range(0, SZ + 3) - 2;
            vp = my + $urandom_range(0, SZ + 3) - 2;
            if (hp < 0) hp = 0;
            if (vp < 0) vp = 0;
            if (hp > 639) hp = 639;
            if (vp > 479) vp = 479;
        end else begin
            hp = $urandom_range(0, 639);
            vp = $urandom_range(0, 479);
        end
        tick($urandom_range(0, 7) != 0, $urandom, $urandom, 1'b0, hp, vp,
             $urandom, $urandom_range(0, 3), -1);
    endtask

    // A frame: the v_begin tick lies in blanking, then random pixels.
    task automatic frame(input int npx, input bit pz, input int spd);
        tick(1'b0, 1'b1, 1'b0, 1'b1, 0, 0, pz, spd, -1);
        for (int i = 0; i < npx; i++) rand_pixel();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; clk_en = 1'b0; v_begin = 1'b0;
        #1;
        check("rst_rgb", {26'd0, r, g, b}, 32'd0);
        check("rst_hs", {31'd0, hsync_o}, 32'd1);
        check("rst_vs", {31'd0, vsync_o}, 32'd1);
        check("rst_bounces", {24'd0, bounces}, 32'd0);
        repeat (3) @(negedge clk);
        sb.delete();
        model_reset();
        rst_n = 1'b1;
    endtask

    // Monitor: each clk_en tick presents the pixel issued two ticks earlier.
    always @(posedge clk) begin
        if (rst_n && clk_en) begin
            #1;
            if (sb.size() >= 2) begin
                mon_e = sb.pop_front();
                check($sformatf("rgb%0d", mon_e.id), {26'd0, r, g, b}, {26'd0, mon_e.rgb});
                check($sformatf("hsync_o%0d", mon_e.id), {31'd0, hsync_o}, {31'd0, mon_e.hs});
                check($sformatf("vsync_o%0d", mon_e.id), {31'd0, vsync_o}, {31'd0, mon_e.vs});
            end
        end
    end

    initial begin
        rst_n = 1'b0; clk_en = 1'b0; active = 1'b0; hsync = 1'b1; vsync = 1'b1;
        v_begin = 1'b0; hpos = 10'd0; vpos = 10'd0; pause = 1'b0; speed = 2'd0;
        model_reset();
        repeat (2) @(negedge clk);
        do_reset();

        // Gating: clk_en low with toggling inputs must leave every output alone.
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            active = 1'b1; hsync = $urandom; vsync = $urandom; pause = $urandom;
            hpos = $urandom; vpos = $urandom; speed = $urandom;
        end
        #1;
        check("gate_rgb", {26'd0, r, g, b}, 32'd0);
        check("gate_hs", {31'd0, hsync_o}, 32'd1);
        check("gate_vs", {31'd0, vsync_o}, 32'd1);
        check("gate_bounces", {24'd0, bounces}, 32'd0);

        // Ten frames at speed 3 put the sprite at (40,40).
        for (int f = 0; f < 10; f++) frame(6, 1'b0, 3);
        tick(1'b1, 1'b0, 1'b1, 1'b0, 40, 40, 1'b0, 0, 6'b11_11_11);
        tick(1'b1, 1'b1, 1'b0, 1'b0, 41, 41, 1'b0, 1, 6'b11_00_00);
        tick(1'b1, 1'b1, 1'b1, 1'b0, 72, 64, 1'b0, 2, 6'b01_01_01);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 72, 72, 1'b0, 3, 6'b00_00_00);
        tick(1'b0, 1'b1, 1'b1, 1'b0, 41, 41, 1'b0, 3, 6'b00_00_00);

        // Pause across five frames: sprite and palette stay put.
        for (int f = 0; f < 5; f++) frame(4, 1'b1, $urandom_range(0, 3));
        tick(1'b1, 1'b1, 1'b1, 1'b0, 40, 40, 1'b0, 0, 6'b11_11_11);
        tick(1'b1, 1'b1, 1'b1, 1'b0, 71, 71, 1'b0, 0, 6'b11_11_11);
        tick(1'b1, 1'b1, 1'b1, 1'b0, 41, 41, 1'b0, 0, 6'b11_00_00);

        // Long random run: wall hits, palette cycling, clamping at both limits.
        for (int f = 0; f < 320; f++) frame(12, ($urandom_range(0, 4) == 0), $urandom_range(0, 3));

        // Reset in the middle of a frame, then resume.
        for (int i = 0; i < 5; i++) rand_pixel();
        do_reset();
        for (int f = 0; f < 8; f++) frame(8, 1'b0, $urandom_range(0, 3));

        // Flush the pipe with blank ticks.
        tick(1'b0, 1'b1, 1'b1, 1'b0, 0, 0, 1'b0, 0, -1);
        tick(1'b0, 1'b1, 1'b1, 1'b0, 0, 0, 1'b0, 0, -1);
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
